// File: rtl/beam_thresh_loader.sv
// Threshold staging table plus load sequencer for the dual-beam trigger slices.
// Latency: commit to done_o is NBEAMS+2 cycles; readback (BEAM_THRESH_READBACK_EN) is 1 cycle.
// Backpressure: none; writes are rejected with wr_err_o and commits are dropped while not IDLE.
module beam_thresh_loader #(
    parameter int          NBEAMS         = 48,
    parameter logic [17:0] DEFAULT_THRESH = 18'h3FFFF,
    parameter int          ADDR_BITS      = $clog2(NBEAMS)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 thr_wr_i,
    input  logic [ADDR_BITS-1:0] thr_addr_i,
    input  logic [17:0]          thr_dat_i,
    output logic                 wr_err_o,
    input  logic                 commit_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [17:0]          thresh_o,
    output logic [NBEAMS-1:0]    thresh_ce_o,
    output logic                 update_o
`ifdef BEAM_THRESH_READBACK_EN
    ,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic [17:0]          rd_dat_o
`endif
);

    // Internal index width is exactly what the table needs; the port address may be wider.
    localparam int IDX_W = $clog2(NBEAMS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_UPDATE,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;

    // Staging table is deliberately outside reset; it powers up to DEFAULT_THRESH.
    logic [17:0]        r_stage [NBEAMS] = '{default: DEFAULT_THRESH};

    logic [17:0]        r_thresh;
    logic               r_wr_err;

    logic               w_addr_ok;
    logic [IDX_W-1:0]   w_wr_idx;
    logic               w_wr_ok;
    logic               w_wr_rej;
    logic               w_last;
    logic               w_busy;
    logic               w_done;
    logic               w_update;
    logic [NBEAMS-1:0]  w_ce;
    logic               w_ld_en;
    logic [IDX_W-1:0]   w_ld_addr;
    logic [17:0]        w_ld_dat;

    assign w_addr_ok = (32'(thr_addr_i) < NBEAMS);
    assign w_wr_idx  = thr_addr_i[IDX_W-1:0];
    assign w_wr_ok   = thr_wr_i && (r_state == ST_IDLE) && w_addr_ok;
    assign w_wr_rej  = thr_wr_i && !w_wr_ok;
    assign w_last    = (r_idx == IDX_W'(NBEAMS - 1));

    // Single read port feeding the bus register; a same-cycle write to the
    // entry being fetched is forwarded so commit sees the newest value.
    assign w_ld_dat  = (w_wr_ok && (w_wr_idx == w_ld_addr)) ? thr_dat_i : r_stage[w_ld_addr];

    // Next-state, sequence counter and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_update    = 1'b0;
        w_ce        = '0;
        w_ld_en     = 1'b0;
        w_ld_addr   = '0;
        case (r_state)
            ST_IDLE: begin
                if (commit_i) begin
                    w_state_nxt = ST_LOAD;
                    w_idx_nxt   = '0;
                    w_ld_en     = 1'b1;
                    w_ld_addr   = '0;
                end
            end
            ST_LOAD: begin
                w_busy = 1'b1;
                w_ce   = NBEAMS'(1) << r_idx;
                if (w_last) begin
                    w_state_nxt = ST_UPDATE;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                    w_ld_en   = 1'b1;
                    w_ld_addr = r_idx + IDX_W'(1);
                end
            end
            ST_UPDATE: begin
                // CE is already low here, so every first-stage register holds its new value.
                w_busy      = 1'b1;
                w_update    = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and sequence index.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Bus data register (holds its last value outside LOAD) and write-error pulse.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_thresh <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_wr_rej;
            if (w_ld_en) begin
                r_thresh <= w_ld_dat;
            end
        end
    end

    // Staging table writes, only accepted while idle.
    always_ff @(posedge clk_i) begin
        if (w_wr_ok) begin
            r_stage[w_wr_idx] <= thr_dat_i;
        end
    end

`ifdef BEAM_THRESH_READBACK_EN
    logic [17:0] r_rd_dat;
    logic        w_rd_ok;

    assign w_rd_ok = (32'(rd_addr_i) < NBEAMS);

    // Registered readback port, independent of the load sequence.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_rd_dat <= '0;
        end else begin
            r_rd_dat <= w_rd_ok ? r_stage[rd_addr_i[IDX_W-1:0]] : '0;
        end
    end

    assign rd_dat_o = r_rd_dat;
`endif

    assign thresh_o    = r_thresh;
    assign thresh_ce_o = w_ce;
    assign update_o    = w_update;
    assign busy_o      = w_busy;
    assign done_o      = w_done;
    assign wr_err_o    = r_wr_err;

endmodule

// File: tb/tb_beam_thresh_loader.sv
// Directed bench for beam_thresh_loader with NBEAMS=4 and a 3-bit address.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// Readback checks are compiled in only when BEAM_THRESH_READBACK_EN is defined.
module tb_beam_thresh_loader;

    localparam int NB = 4;
    localparam int AB = 3;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          thr_wr_i;
    logic [AB-1:0] thr_addr_i;
    logic [17:0]   thr_dat_i;
    logic          wr_err_o;
    logic          commit_i;
    logic          busy_o;
    logic          done_o;
    logic [17:0]   thresh_o;
    logic [NB-1:0] thresh_ce_o;
    logic          update_o;
`ifdef BEAM_THRESH_READBACK_EN
    logic [AB-1:0] rd_addr_i;
    logic [17:0]   rd_dat_o;
`endif

    int total = 0;
    int bad   = 0;

    beam_thresh_loader #(
        .NBEAMS    (NB),
        .ADDR_BITS (AB)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .thr_wr_i    (thr_wr_i),
        .thr_addr_i  (thr_addr_i),
        .thr_dat_i   (thr_dat_i),
        .wr_err_o    (wr_err_o),
        .commit_i    (commit_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .thresh_o    (thresh_o),
        .thresh_ce_o (thresh_ce_o),
        .update_o    (update_o)
`ifdef BEAM_THRESH_READBACK_EN
        ,
        .rd_addr_i   (rd_addr_i),
        .rd_dat_o    (rd_dat_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_thresh"}, 32'(thresh_o), 32'h0);
        chk({tag, "_ce"},     32'(thresh_ce_o), 32'h0);
        chk({tag, "_update"}, 32'(update_o), 32'h0);
        chk({tag, "_busy"},   32'(busy_o), 32'h0);
        chk({tag, "_done"},   32'(done_o), 32'h0);
        chk({tag, "_wrerr"},  32'(wr_err_o), 32'h0);
    endtask

    // Caller has commit_i=1 in the current cycle c. Checks c+1 .. c+NB+3.
    // bad_wr: issue a write of 5 to beam 0 during the first LOAD cycle.
    task automatic run_load(input string tag, input logic [18*NB-1:0] exp_vec, input bit bad_wr);
        tick();
        commit_i = 1'b0;
        thr_wr_i = 1'b0;
        for (int i = 0; i < NB; i++) begin
            chk({tag, "_ce"},    32'(thresh_ce_o), 32'(1) << i);
            chk({tag, "_bus"},   32'(thresh_o), 32'(exp_vec[18*i +: 18]));
            chk({tag, "_busy"},  32'(busy_o), 32'h1);
            chk({tag, "_upd0"},  32'(update_o), 32'h0);
            chk({tag, "_wrerr"}, 32'(wr_err_o), (bad_wr && i == 1) ? 32'h1 : 32'h0);
            if (bad_wr && i == 0) begin
                thr_wr_i   = 1'b1;
                thr_addr_i = 3'd0;
                thr_dat_i  = 18'd5;
            end
            tick();
            thr_wr_i = 1'b0;
        end
        chk({tag, "_upd"},      32'(update_o), 32'h1);
        chk({tag, "_upd_ce"},   32'(thresh_ce_o), 32'h0);
        chk({tag, "_upd_busy"}, 32'(busy_o), 32'h1);
        chk({tag, "_upd_hold"}, 32'(thresh_o), 32'(exp_vec[18*(NB-1) +: 18]));
        tick();
        chk({tag, "_done"},      32'(done_o), 32'h1);
        chk({tag, "_done_busy"}, 32'(busy_o), 32'h0);
        chk({tag, "_done_upd"},  32'(update_o), 32'h0);
        tick();
        chk({tag, "_post_done"}, 32'(done_o), 32'h0);
        chk({tag, "_post_busy"}, 32'(busy_o), 32'h0);
    endtask

    initial begin
        rstn_i     = 1'b0;
        thr_wr_i   = 1'b0;
        thr_addr_i = '0;
        thr_dat_i  = '0;
        commit_i   = 1'b0;
`ifdef BEAM_THRESH_READBACK_EN
        rd_addr_i  = '0;
`endif
        tick();
        tick();
        chk_idle_outs("reset");
        rstn_i = 1'b1;
        tick();

        // Default table load.
        commit_i = 1'b1;
        run_load("dflt", {18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF}, 1'b0);

        // Writes, with the beam2 write in the commit cycle (write-first).
        thr_wr_i = 1'b1; thr_addr_i = 3'd1; thr_dat_i = 18'h13880;
        tick();
        chk("wr1_ok", 32'(wr_err_o), 32'h0);
        thr_addr_i = 3'd2; thr_dat_i = 18'h04E20;
        commit_i = 1'b1;
        run_load("wrfirst", {18'h3FFFF, 18'h04E20, 18'h13880, 18'h3FFFF}, 1'b0);

        // Write during busy is rejected and staging is unchanged.
        commit_i = 1'b1;
        run_load("busywr", {18'h3FFFF, 18'h04E20, 18'h13880, 18'h3FFFF}, 1'b1);

        // Out-of-range address in IDLE.
        thr_wr_i = 1'b1; thr_addr_i = 3'd4; thr_dat_i = 18'h00007;
        tick();
        thr_wr_i = 1'b0;
        chk("oor_err", 32'(wr_err_o), 32'h1);
        tick();
        chk("oor_err_clr", 32'(wr_err_o), 32'h0);
        commit_i = 1'b1;
        run_load("after_err", {18'h3FFFF, 18'h04E20, 18'h13880, 18'h3FFFF}, 1'b0);

        // commit_i held high: one update every NB+3 cycles, commit in DONE ignored.
        commit_i = 1'b1;
        for (int k = 1; k <= 3 * (NB + 3); k++) begin
            tick();
            chk("hold_upd",  32'(update_o), ((k % (NB + 3)) == NB + 1) ? 32'h1 : 32'h0);
            chk("hold_done", 32'(done_o),   ((k % (NB + 3)) == NB + 2) ? 32'h1 : 32'h0);
            chk("hold_busy", 32'(busy_o),
                ((k % (NB + 3)) >= 1 && (k % (NB + 3)) <= NB + 1) ? 32'h1 : 32'h0);
            if (k == 3 * (NB + 3) - 1) commit_i = 1'b0;
        end

        // Reset asserted in the middle of a load.
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        tick();
        rstn_i = 1'b0;
        tick();
        chk_idle_outs("midrst");
        rstn_i = 1'b1;
        for (int k = 0; k < NB + 4; k++) begin
            tick();
            chk("midrst_noupd", 32'(update_o), 32'h0);
            chk("midrst_idle",  32'(busy_o), 32'h0);
        end
        commit_i = 1'b1;
        run_load("postrst", {18'h3FFFF, 18'h04E20, 18'h13880, 18'h3FFFF}, 1'b0);

`ifdef BEAM_THRESH_READBACK_EN
        thr_wr_i = 1'b1; thr_addr_i = 3'd3; thr_dat_i = 18'h00123;
        tick();
        thr_wr_i = 1'b0;
        rd_addr_i = 3'd3;
        tick();
        chk("rb_idle", 32'(rd_dat_o), 32'h00123);
        rd_addr_i = 3'd1;
        tick();
        chk("rb_b1", 32'(rd_dat_o), 32'h13880);
        rd_addr_i = 3'd5;
        tick();
        chk("rb_oor", 32'(rd_dat_o), 32'h0);
        rd_addr_i = 3'd3;
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        tick();
        chk("rb_busy_st", 32'(busy_o), 32'h1);
        chk("rb_busy", 32'(rd_dat_o), 32'h00123);
        rstn_i = 1'b0;
        tick();
        chk("rb_rst", 32'(rd_dat_o), 32'h0);
        rstn_i = 1'b1;
        tick();
        chk("rb_after_rst", 32'(rd_dat_o), 32'h00123);
        commit_i = 1'b1;
        run_load("rbload", {18'h00123, 18'h04E20, 18'h13880, 18'h3FFFF}, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
